// File: rtl/mem_line_arbiter.sv
// ---------------------------------------------------------------------------
// mem_line_arbiter
//
// Shares one 128-bit line-wide memory port between the instruction cache
// (line reads only) and the data cache (line reads and line writes).
//
// Each access runs through three phases:
//   1. Grant one requester and latch its command.
//   2. Hold the command on the memory port for MEM_LAT cycles.
//   3. Return the line to the granted requester with a one-cycle valid pulse.
//
// Optional feature macro:
//   MEM_ARB_RR_EN  when defined, conflicts are resolved round-robin using the
//                  last granted requester. When undefined (default), the dcache
//                  wins every conflict.
//
// Parameters:
//   LINE_BITS  line-index width (byte address bits [19:4])
//   LINE_W     line data width, four 32-bit words, word0 in [31:0]
//   MEM_LAT    memory access cycles, 1..255
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   Ic_mem_req / Ic_mem_addr        icache line-read request, held until F_mem_valid
//   F_mem_inst / F_mem_valid        line returned to icache, one-cycle valid pulse
//   Dc_mem_req / Dc_mem_we          dcache request (held until M_mem_valid), write flag
//   Dc_mem_addr / Dc_mem_wdata      dcache line index, eviction line
//   M_mem_data / M_mem_valid        read line to dcache, one-cycle valid / write-done pulse
//   mem_req / mem_we                memory access in progress, write enable
//   mem_addr / mem_wdata            memory line index, write line
//   mem_rdata                       memory read line, valid in the final BUSY cycle
// ---------------------------------------------------------------------------
module mem_line_arbiter #(
    parameter int LINE_BITS = 16,
    parameter int LINE_W    = 128,
    parameter int MEM_LAT   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 Ic_mem_req,
    input  logic [LINE_BITS-1:0] Ic_mem_addr,
    output logic [LINE_W-1:0]    F_mem_inst,
    output logic                 F_mem_valid,
    input  logic                 Dc_mem_req,
    input  logic                 Dc_mem_we,
    input  logic [LINE_BITS-1:0] Dc_mem_addr,
    input  logic [LINE_W-1:0]    Dc_mem_wdata,
    output logic [LINE_W-1:0]    M_mem_data,
    output logic                 M_mem_valid,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [LINE_BITS-1:0] mem_addr,
    output logic [LINE_W-1:0]    mem_wdata,
    input  logic [LINE_W-1:0]    mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

    localparam logic [7:0] LAST_CNT = 8'(MEM_LAT - 1);

    state_t               r_state;
    owner_t               r_owner;
    owner_t               r_lastGrant;
    logic [7:0]           r_cnt;
    logic                 r_memReq;
    logic                 r_memWe;
    logic [LINE_BITS-1:0] r_memAddr;
    logic [LINE_W-1:0]    r_memWdata;
    logic [LINE_W-1:0]    r_fInst;
    logic                 r_fValid;
    logic [LINE_W-1:0]    r_mData;
    logic                 r_mValid;

    logic                 w_anyReq;
    logic                 w_grantDc;

    assign w_anyReq = Ic_mem_req | Dc_mem_req;

`ifdef MEM_ARB_RR_EN
    // A single requester always wins. On a conflict the dcache wins only
    // when the icache had the previous grant.
    assign w_grantDc = Dc_mem_req & (~Ic_mem_req | (r_lastGrant == OWN_IC));
`else
    // Fixed priority: the dcache wins every conflict. The grant history is
    // still tracked so both builds hold the same state.
    logic w_unusedLastGrant;
    assign w_grantDc         = Dc_mem_req;
    assign w_unusedLastGrant = r_lastGrant;
`endif

    // Single controller. Every output is a register, so the memory port and
    // both response ports change only on clock edges or on reset.
    // Reset drops any in-flight access. A requester that still holds its
    // request simply re-arbitrates once reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_IC;
            r_lastGrant <= OWN_IC;
            r_cnt       <= 8'd0;
            r_memReq    <= 1'b0;
            r_memWe     <= 1'b0;
            r_memAddr   <= '0;
            r_memWdata  <= '0;
            r_fInst     <= '0;
            r_fValid    <= 1'b0;
            r_mData     <= '0;
            r_mValid    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_fValid <= 1'b0;
                    r_mValid <= 1'b0;
                    if (w_anyReq) begin
                        r_cnt    <= 8'd0;
                        r_memReq <= 1'b1;
                        r_state  <= ST_BUSY;
                        if (w_grantDc) begin
                            r_owner     <= OWN_DC;
                            r_lastGrant <= OWN_DC;
                            r_memWe     <= Dc_mem_we;
                            r_memAddr   <= Dc_mem_addr;
                            r_memWdata  <= Dc_mem_wdata;
                        end else begin
                            r_owner     <= OWN_IC;
                            r_lastGrant <= OWN_IC;
                            r_memWe     <= 1'b0;
                            r_memAddr   <= Ic_mem_addr;
                        end
                    end
                end

                // Requester inputs are ignored here. The last edge captures
                // the read line; on a write the dcache data register keeps
                // its old value.
                ST_BUSY: begin
                    if (r_cnt == LAST_CNT) begin
                        r_cnt    <= 8'd0;
                        r_memReq <= 1'b0;
                        r_memWe  <= 1'b0;
                        r_state  <= ST_RESP;
                        if (r_owner == OWN_IC) begin
                            r_fInst  <= mem_rdata;
                            r_fValid <= 1'b1;
                        end else begin
                            if (!r_memWe) begin
                                r_mData <= mem_rdata;
                            end
                            r_mValid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                // The valid pulse lasts exactly one cycle. Arbitration waits
                // for the following IDLE cycle.
                ST_RESP: begin
                    r_fValid <= 1'b0;
                    r_mValid <= 1'b0;
                    r_state  <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req     = r_memReq;
    assign mem_we      = r_memWe;
    assign mem_addr    = r_memAddr;
    assign mem_wdata   = r_memWdata;
    assign F_mem_inst  = r_fInst;
    assign F_mem_valid = r_fValid;
    assign M_mem_data  = r_mData;
    assign M_mem_valid = r_mValid;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_line_arbiter
//
// Directed testbench for mem_line_arbiter.
//   dut   uses MEM_LAT=4.
//   dut1  uses MEM_LAT=1.
//
// Cycle numbering: cycle 0 is the cycle in which a request is first driven.
// Outputs are sampled 1 time unit after each rising edge, and inputs are
// changed right after sampling.
// ---------------------------------------------------------------------------
module tb_mem_line_arbiter;

    logic         clk;
    logic         rst_n;

    logic         icReq;
    logic [15:0]  icAddr;
    logic [127:0] fInst;
    logic         fValid;
    logic         dcReq;
    logic         dcWe;
    logic [15:0]  dcAddr;
    logic [127:0] dcWdata;
    logic [127:0] mData;
    logic         mValid;
    logic         memReq;
    logic         memWe;
    logic [15:0]  memAddr;
    logic [127:0] memWdata;
    logic [127:0] memRdata;

    logic         icReq1;
    logic [15:0]  icAddr1;
    logic [127:0] fInst1;
    logic         fValid1;
    logic         dcReq1;
    logic         dcWe1;
    logic [15:0]  dcAddr1;
    logic [127:0] dcWdata1;
    logic [127:0] mData1;
    logic         mValid1;
    logic         memReq1;
    logic         memWe1;
    logic [15:0]  memAddr1;
    logic [127:0] memWdata1;
    logic [127:0] memRdata1;

    int nVec;
    int nBad;

    localparam logic [127:0] IC_LINE = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
    localparam logic [127:0] DC_LINE = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] WR_RD   = 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC;

    mem_line_arbiter #(.LINE_BITS(16), .LINE_W(128), .MEM_LAT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .Ic_mem_req(icReq), .Ic_mem_addr(icAddr),
        .F_mem_inst(fInst), .F_mem_valid(fValid),
        .Dc_mem_req(dcReq), .Dc_mem_we(dcWe), .Dc_mem_addr(dcAddr), .Dc_mem_wdata(dcWdata),
        .M_mem_data(mData), .M_mem_valid(mValid),
        .mem_req(memReq), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
        .mem_rdata(memRdata)
    );

    mem_line_arbiter #(.LINE_BITS(16), .LINE_W(128), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .Ic_mem_req(icReq1), .Ic_mem_addr(icAddr1),
        .F_mem_inst(fInst1), .F_mem_valid(fValid1),
        .Dc_mem_req(dcReq1), .Dc_mem_we(dcWe1), .Dc_mem_addr(dcAddr1), .Dc_mem_wdata(dcWdata1),
        .M_mem_data(mData1), .M_mem_valid(mValid1),
        .mem_req(memReq1), .mem_we(memWe1), .mem_addr(memAddr1), .mem_wdata(memWdata1),
        .mem_rdata(memRdata1)
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guards against a hang if the run never reaches the summary.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    // Checks outputs while reset is held, then asserts reset in the middle
    // of a BUSY access and checks that the outputs clear before any edge.
    task automatic test_reset;
        rst_n = 1'b0;
        icReq = 0; icAddr = '0; dcReq = 0; dcWe = 0; dcAddr = '0; dcWdata = '0; memRdata = '0;
        icReq1 = 0; icAddr1 = '0; dcReq1 = 0; dcWe1 = 0; dcAddr1 = '0; dcWdata1 = '0; memRdata1 = '0;
        nextCycle();
        nextCycle();
        nVec++;
        if (memReq !== 1'b0 || memWe !== 1'b0 || memAddr !== 16'h0 || memWdata !== 128'h0) begin
            nBad++;
            $display("[TB] FAIL reset memport: got req=%b we=%b addr=%h, expected all 0",
                     memReq, memWe, memAddr);
        end
        nVec++;
        if (fValid !== 1'b0 || mValid !== 1'b0 || fInst !== 128'h0 || mData !== 128'h0) begin
            nBad++;
            $display("[TB] FAIL reset resp: got fv=%b mv=%b, expected 0", fValid, mValid);
        end
        rst_n = 1'b1;
        nextCycle();

        // Start an icache access, then assert reset mid-BUSY.
        icReq = 1'b1; icAddr = 16'h0ABC;
        nextCycle();
        nextCycle();
        nVec++;
        if (memReq !== 1'b1) begin
            nBad++;
            $display("[TB] FAIL reset busy-before: got mem_req=%b expected 1", memReq);
        end
        #2 rst_n = 1'b0;
        #1;
        nVec++;
        if (memReq !== 1'b0 || fValid !== 1'b0 || mValid !== 1'b0) begin
            nBad++;
            $display("[TB] FAIL reset async: got req=%b fv=%b mv=%b expected 0 0 0",
                     memReq, fValid, mValid);
        end
        #1 rst_n = 1'b1;

        // The request is still held, so it re-arbitrates after release.
        nextCycle();
        nVec++;
        if (memReq !== 1'b1 || memAddr !== 16'h0ABC) begin
            nBad++;
            $display("[TB] FAIL reset rearb: got req=%b addr=%h expected 1 0abc", memReq, memAddr);
        end
        for (int k = 0; k < 10; k++) begin
            nextCycle();
            if (fValid) begin
                icReq = 1'b0;
                break;
            end
        end
        nVec++;
        if (icReq !== 1'b0) begin
            nBad++;
            $display("[TB] FAIL reset completion: got no F_mem_valid, expected one");
            icReq = 1'b0;
        end
        nextCycle();
    endtask

    task automatic test_icache_miss;
        logic eReq;
        logic eVal;
        memRdata = IC_LINE;
        icReq = 1'b1; icAddr = 16'h0012;
        for (int k = 1; k <= 6; k++) begin
            nextCycle();
            eReq = (k <= 4);
            eVal = (k == 5);
            nVec++;
            if (memReq !== eReq || (eReq && (memAddr !== 16'h0012 || memWe !== 1'b0))) begin
                nBad++;
                $display("[TB] FAIL icache memport cyc%0d: got req=%b addr=%h we=%b expected req=%b addr=0012 we=0",
                         k, memReq, memAddr, memWe, eReq);
            end
            nVec++;
            if (fValid !== eVal || mValid !== 1'b0) begin
                nBad++;
                $display("[TB] FAIL icache valid cyc%0d: got fv=%b mv=%b expected fv=%b mv=0",
                         k, fValid, mValid, eVal);
            end
            if (k == 5) begin
                nVec++;
                if (fInst !== IC_LINE) begin
                    nBad++;
                    $display("[TB] FAIL icache line: got %h expected %h", fInst, IC_LINE);
                end
                icReq = 1'b0;
            end
        end
    endtask

    task automatic test_dcache_read;
        memRdata = DC_LINE;
        dcReq = 1'b1; dcWe = 1'b0; dcAddr = 16'h0200;
        for (int k = 1; k <= 6; k++) begin
            nextCycle();
            if (k == 2) begin
                dcAddr = 16'hFFFF;
            end
            nVec++;
            if ((k <= 4) && (memReq !== 1'b1 || memAddr !== 16'h0200 || memWe !== 1'b0)) begin
                nBad++;
                $display("[TB] FAIL dread memport cyc%0d: got req=%b addr=%h we=%b expected 1 0200 0",
                         k, memReq, memAddr, memWe);
            end else if ((k > 4) && memReq !== 1'b0) begin
                nBad++;
                $display("[TB] FAIL dread memport cyc%0d: got req=%b expected 0", k, memReq);
            end
            nVec++;
            if (mValid !== (k == 5) || fValid !== 1'b0) begin
                nBad++;
                $display("[TB] FAIL dread valid cyc%0d: got mv=%b fv=%b", k, mValid, fValid);
            end
            if (k == 5) begin
                nVec++;
                if (mData !== DC_LINE) begin
                    nBad++;
                    $display("[TB] FAIL dread line: got %h expected %h", mData, DC_LINE);
                end
                dcReq = 1'b0;
            end
        end
    endtask

    task automatic test_dcache_write;
        memRdata = WR_RD;
        dcReq = 1'b1; dcWe = 1'b1; dcAddr = 16'h0100; dcWdata = 128'h1;
        for (int k = 1; k <= 6; k++) begin
            nextCycle();
            nVec++;
            if ((k <= 4) && (memReq !== 1'b1 || memWe !== 1'b1 || memAddr !== 16'h0100 || memWdata !== 128'h1)) begin
                nBad++;
                $display("[TB] FAIL dwrite memport cyc%0d: got req=%b we=%b addr=%h wdata=%h expected 1 1 0100 1",
                         k, memReq, memWe, memAddr, memWdata);
            end else if ((k > 4) && memReq !== 1'b0) begin
                nBad++;
                $display("[TB] FAIL dwrite memport cyc%0d: got req=%b expected 0", k, memReq);
            end
            nVec++;
            if (mValid !== (k == 5)) begin
                nBad++;
                $display("[TB] FAIL dwrite valid cyc%0d: got mv=%b expected %b", k, mValid, (k == 5));
            end
            if (k == 5) begin
                nVec++;
                if (mData !== DC_LINE) begin
                    nBad++;
                    $display("[TB] FAIL dwrite mdata: got %h expected unchanged %h", mData, DC_LINE);
                end
                dcReq = 1'b0; dcWe = 1'b0;
            end
        end
    endtask

`ifdef MEM_ARB_RR_EN
    // Round-robin grant order. After reset, two back-to-back conflicts are
    // expected to grant D, I, D, I. A lone icache request is then granted
    // every time.
    task automatic test_conflict;
        string order;
        order = "";
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        nextCycle();
        memRdata = DC_LINE;
        for (int r = 0; r < 2; r++) begin
            icReq = 1'b1; icAddr = 16'h0010;
            dcReq = 1'b1; dcWe = 1'b0; dcAddr = 16'h0020;
            for (int k = 0; k < 30 && (icReq || dcReq); k++) begin
                nextCycle();
                if (mValid) begin
                    order = {order, "D"};
                    dcReq = 1'b0;
                end
                if (fValid) begin
                    order = {order, "I"};
                    icReq = 1'b0;
                end
            end
            icReq = 1'b0; dcReq = 1'b0;
        end
        nVec++;
        if (order != "DIDI") begin
            nBad++;
            $display("[TB] FAIL rr order: got %s expected DIDI", order);
        end
        for (int r = 0; r < 2; r++) begin
            icReq = 1'b1; icAddr = 16'h0030;
            for (int k = 0; k < 8 && icReq; k++) begin
                nextCycle();
                if (fValid) begin
                    icReq = 1'b0;
                end
            end
            nVec++;
            if (icReq !== 1'b0) begin
                nBad++;
                $display("[TB] FAIL rr ic-alone round %0d: got no grant, expected grant", r);
                icReq = 1'b0;
            end
            nextCycle();
        end
    endtask
`else
    // Fixed priority. The dcache is served first with valid in cycle 5.
    // The icache is granted in cycle 6 and gets F_mem_valid in cycle 11.
    task automatic test_conflict;
        logic [15:0] eAddr;
        logic        eReq;
        memRdata = IC_LINE;
        icReq = 1'b1; icAddr = 16'h0012;
        dcReq = 1'b1; dcWe = 1'b0; dcAddr = 16'h0034;
        for (int k = 1; k <= 12; k++) begin
            nextCycle();
            eReq  = (k <= 4) || (k >= 7 && k <= 10);
            eAddr = (k <= 4) ? 16'h0034 : 16'h0012;
            nVec++;
            if (memReq !== eReq || (eReq && memAddr !== eAddr)) begin
                nBad++;
                $display("[TB] FAIL conflict memport cyc%0d: got req=%b addr=%h expected req=%b addr=%h",
                         k, memReq, memAddr, eReq, eAddr);
            end
            nVec++;
            if (mValid !== (k == 5) || fValid !== (k == 11)) begin
                nBad++;
                $display("[TB] FAIL conflict valid cyc%0d: got mv=%b fv=%b expected mv=%b fv=%b",
                         k, mValid, fValid, (k == 5), (k == 11));
            end
            if (k == 5) dcReq = 1'b0;
            if (k == 11) icReq = 1'b0;
        end
    endtask
`endif

    // Single-cycle latency on dut1. The address input changes in cycle 1 and
    // must not disturb the latched command.
    task automatic test_lat1;
        memRdata1 = DC_LINE;
        icReq1 = 1'b1; icAddr1 = 16'h0077;
        nextCycle();
        nVec++;
        if (memReq1 !== 1'b1 || memAddr1 !== 16'h0077 || fValid1 !== 1'b0) begin
            nBad++;
            $display("[TB] FAIL lat1 cyc1: got req=%b addr=%h fv=%b expected 1 0077 0",
                     memReq1, memAddr1, fValid1);
        end
        icAddr1 = 16'h0F0F;
        nextCycle();
        nVec++;
        if (memReq1 !== 1'b0 || fValid1 !== 1'b1 || fInst1 !== DC_LINE || memAddr1 !== 16'h0077) begin
            nBad++;
            $display("[TB] FAIL lat1 cyc2: got req=%b fv=%b addr=%h line=%h expected 0 1 0077 %h",
                     memReq1, fValid1, memAddr1, fInst1, DC_LINE);
        end
        icReq1 = 1'b0;
        nextCycle();
        nVec++;
        if (fValid1 !== 1'b0 || memReq1 !== 1'b0 || mValid1 !== 1'b0) begin
            nBad++;
            $display("[TB] FAIL lat1 cyc3: got fv=%b req=%b mv=%b expected 0 0 0",
                     fValid1, memReq1, mValid1);
        end
    endtask

    // Runs every scenario in sequence and prints the summary.
    initial begin
        nVec = 0;
        nBad = 0;
        test_reset();
        test_icache_miss();
        test_dcache_read();
        test_dcache_write();
        test_conflict();
        test_lat1();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
